// File: rtl/fft_pkg.sv
// Shared constants and complex-sample types for the FFT_R2SDF pipeline.
// Only sixth_stage and buffer_2 use this package.
package fft_pkg;

  localparam int STG6_IN_W     = 36;
  localparam int STG6_OUT_W    = 37;
  localparam int FFT_FRAME_LEN = 128;
  localparam int STG6_DELAY    = 2;
  localparam int FFT_CNT_W     = 8;

  // Counter value on the last drain cycle; the counter wraps to 0 after it.
  localparam logic [FFT_CNT_W-1:0] STG6_CNT_LAST = FFT_CNT_W'(FFT_FRAME_LEN + STG6_DELAY - 1);

  typedef struct packed {
    logic signed [STG6_IN_W-1:0] re;
    logic signed [STG6_IN_W-1:0] im;
  } cplx_in_t;

  typedef struct packed {
    logic signed [STG6_OUT_W-1:0] re;
    logic signed [STG6_OUT_W-1:0] im;
  } cplx_out_t;

  // Multiply by -j: (re, im) -> (im, -re).
  function automatic cplx_out_t rot_mj(input cplx_out_t a);
    cplx_out_t r;
    r.re = a.im;
    r.im = -a.re;
    return r;
  endfunction

endpackage

// File: rtl/buffer_2.sv
// Enable-gated complex shift register, STG6_DELAY entries deep, 37 bits per
// component. dout is the oldest entry; asynchronous active-low clear to 0.
module buffer_2
  import fft_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      en,
  input  cplx_out_t din,
  output cplx_out_t dout
);

  cplx_out_t mem_q [STG6_DELAY];
  cplx_out_t mem_d [STG6_DELAY];

  always_comb begin
    // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
    mem_d = mem_q;
    if (en) begin
      mem_d[0] = din;
      for (int i = 1; i < STG6_DELAY; i++) begin
        mem_d[i] = mem_q[i-1];
      end
    end
  end

  // NOTE: the delay entries are reset because stale samples would otherwise leak into the first butterflies after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STG6_DELAY; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      mem_q <= mem_d;
    end
  end

  assign dout = mem_q[STG6_DELAY-1];

endmodule

// File: rtl/sixth_stage.sv
// R2SDF sixth stage: 2-deep feedback butterfly with trivial twiddles (x1 / x-j).
// Build option FFT_OUT_GATE_EN zeroes the output data on invalid cycles.
module sixth_stage
  import fft_pkg::*;
(
  input  logic                         iClk,
  input  logic                         iRst_n,
  input  logic                         iData_valid,
  input  logic signed [STG6_IN_W-1:0]  iData_Re,
  input  logic signed [STG6_IN_W-1:0]  iData_Im,
  output logic                         oData_valid,
  output logic signed [STG6_OUT_W-1:0] oData_Re,
  output logic signed [STG6_OUT_W-1:0] oData_Im
);

  localparam int CNT_MSB = FFT_CNT_W - 1;

  logic [FFT_CNT_W-1:0] cnt_q, cnt_d;
  logic                 en;
  logic                 data_valid;
  logic                 valid_q, valid_d;
  cplx_out_t            x, d, dl_in, res;
  cplx_out_t            out_q, out_d;

  buffer_2 u_delay (
    .clk   (iClk),
    .rst_n (iRst_n),
    .en    (en),
    .din   (dl_in),
    .dout  (d)
  );

  always_comb begin
    en         = cnt_q[CNT_MSB] | (iData_valid & ~cnt_q[CNT_MSB]);
    data_valid = cnt_q[CNT_MSB] | (iData_valid & (|cnt_q[CNT_MSB-1:1]));

    cnt_d = cnt_q;
    if (en) begin
      cnt_d = (cnt_q == STG6_CNT_LAST) ? '0 : cnt_q + FFT_CNT_W'(1);
    end

    // Input is ignored during drain so nothing from the bus enters the delay line.
    x = '0;
    if (!cnt_q[CNT_MSB]) begin
      x.re = {iData_Re[STG6_IN_W-1], iData_Re};
      x.im = {iData_Im[STG6_IN_W-1], iData_Im};
    end

    if (cnt_q[1]) begin
      dl_in.re = d.re - x.re;
      dl_in.im = d.im - x.im;
      res.re   = d.re + x.re;
      res.im   = d.im + x.im;
    end else begin
      dl_in = x;
      res   = cnt_q[0] ? rot_mj(d) : d;
    end

    valid_d = data_valid;
`ifdef FFT_OUT_GATE_EN
    out_d = data_valid ? res : '0;
`else
    out_d = res;
`endif
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      cnt_q   <= '0;
      valid_q <= 1'b0;
      out_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      out_q   <= out_d;
    end
  end

  assign oData_valid = valid_q;
  assign oData_Re    = out_q.re;
  assign oData_Im    = out_q.im;

endmodule

// File: tb/tb_sixth_stage.sv
// Scoreboard bench for sixth_stage: a pair-level reference model queues the
// expected valid outputs, and a monitor compares them as the DUT emits them.
`timescale 1ns/1ps
module tb_sixth_stage;

  localparam int IW = 36;
  localparam int OW = 37;

  logic                 iClk = 1'b0;
  logic                 iRst_n = 1'b0;
  logic                 iData_valid = 1'b0;
  logic signed [IW-1:0] iData_Re = '0;
  logic signed [IW-1:0] iData_Im = '0;
  logic                 oData_valid;
  logic signed [OW-1:0] oData_Re;
  logic signed [OW-1:0] oData_Im;

  sixth_stage dut (
    .iClk        (iClk),
    .iRst_n      (iRst_n),
    .iData_valid (iData_valid),
    .iData_Re    (iData_Re),
    .iData_Im    (iData_Im),
    .oData_valid (oData_valid),
    .oData_Re    (oData_Re),
    .oData_Im    (oData_Im)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    longint re;
    longint im;
  } cx_t;

  cx_t exp_q[$];
  cx_t fr[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic cx_t mk(input longint r, input longint i);
    cx_t c;
    c.re = r;
    c.im = i;
    return c;
  endfunction

  function automatic longint rnd36();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return longint'($signed(t[IW-1:0]));
  endfunction

  // Reference model: a frame is 32 groups of 4 samples. Group b emits
  // x[b]+x[b+2], x[b+1]+x[b+3], then (x[b]-x[b+2]) and -j*(x[b+1]-x[b+3]),
  // the differences leaving with the first two samples of the next group or in drain.
  task automatic model_accept(input cx_t s);
    int n;
    cx_t a;
    n = fr.size();
    fr.push_back(s);
    case (n % 4)
      2, 3: exp_q.push_back(mk(fr[n-2].re + s.re, fr[n-2].im + s.im));
      0: if (n >= 4) exp_q.push_back(mk(fr[n-4].re - fr[n-2].re, fr[n-4].im - fr[n-2].im));
      default: if (n >= 5) begin
        a = mk(fr[n-4].re - fr[n-2].re, fr[n-4].im - fr[n-2].im);
        exp_q.push_back(mk(a.im, -a.re));
      end
    endcase
    if (n == 127) begin
      exp_q.push_back(mk(fr[124].re - fr[126].re, fr[124].im - fr[126].im));
      a = mk(fr[125].re - fr[127].re, fr[125].im - fr[127].im);
      exp_q.push_back(mk(a.im, -a.re));
      fr.delete();
    end
  endtask

  always @(negedge iClk) begin
    cx_t e;
    if (iRst_n) begin
      if (oData_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", oData_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_re", oData_Re, e.re);
          check("out_im", oData_Im, e.im);
        end
      end
`ifdef FFT_OUT_GATE_EN
      else begin
        check("gated_re", oData_Re, 0);
        check("gated_im", oData_Im, 0);
      end
`endif
    end
  end

  task automatic drive(input longint r, input longint i);
    @(posedge iClk); #1;
    iData_valid = 1'b1;
    iData_Re    = r[IW-1:0];
    iData_Im    = i[IW-1:0];
  endtask

  task automatic send(input longint r, input longint i);
    drive(r, i);
    model_accept(mk(r, i));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge iClk); #1;
      iData_valid = 1'b0;
      iData_Re    = rnd36();
      iData_Im    = rnd36();
    end
  endtask

  // Drain cycles: strobe and data are driven but must be ignored.
  task automatic drain();
    drive(rnd36(), rnd36());
    drive(rnd36(), rnd36());
    idle(1);
  endtask

  task automatic wait_empty(input string name);
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
      @(posedge iClk); #1;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic idle_check(input int n);
    idle(1);
    repeat (n) begin
      @(negedge iClk);
      check("idle_valid", oData_valid, 0);
    end
  endtask

  task automatic do_reset();
    @(posedge iClk); #2;
    iRst_n      = 1'b0;
    iData_valid = 1'b0;
    exp_q.delete();
    fr.delete();
    #1;
    check("rst_valid", oData_valid, 0);
    check("rst_re", oData_Re, 0);
    check("rst_im", oData_Im, 0);
    @(posedge iClk); #1;
    iRst_n = 1'b1;
  endtask

  // kind 0: ramp (n,0); kind 1: random with extremes at positions 0 and 2; kind 2: random.
  task automatic run_frame(input int kind, input int gap_after, input int gap_len, input bit rand_gaps);
    longint r, i;
    for (int n = 0; n < 128; n++) begin
      r = rnd36();
      i = rnd36();
      if (kind == 0) begin
        r = n;
        i = 0;
      end else if (kind == 1 && n == 0) begin
        r = -(64'sd1 <<< 35);
        i = (64'sd1 <<< 35) - 1;
      end else if (kind == 1 && n == 2) begin
        r = (64'sd1 <<< 35) - 1;
        i = -(64'sd1 <<< 35);
      end
      send(r, i);
      if (n == gap_after) idle(gap_len);
      if (rand_gaps && n != 127 && $urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
    end
    drain();
    wait_empty("frame_drained");
    idle_check(4);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge iClk);
    #1;
    check("por_valid", oData_valid, 0);
    check("por_re", oData_Re, 0);
    check("por_im", oData_Im, 0);
    iRst_n = 1'b1;

    // Directed four-sample sequence with two zero samples to flush the differences.
    exp_q.push_back(mk(6, 0));
    exp_q.push_back(mk(9, 0));
    exp_q.push_back(mk(-4, 0));
    exp_q.push_back(mk(0, 5));
    drive(1, 0);
    drive(2, 0);
    drive(5, 0);
    drive(7, 0);
    drive(0, 0);
    drive(0, 0);
    idle(1);
    wait_empty("directed_drained");
    do_reset();

    // Reset in the middle of a frame, right after a valid output is registered.
    for (int n = 0; n < 11; n++) send(rnd36(), rnd36());
    do_reset();
    idle_check(8);

    run_frame(0, -1, 0, 1'b0);
    run_frame(0, 1, 3, 1'b0);
    run_frame(1, -1, 0, 1'b0);
    run_frame(2, -1, 0, 1'b1);
    run_frame(2, 5, 2, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
